// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op encodings and bit-reverse helper for the pipelined barrel shifter
package shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam int MAX_W = 256;

    // Reverses the low w bits of x; bits above w come back as zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] x, input int unsigned w);
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = x[MAX_W-1-i];
        end
        return r >> (MAX_W - w);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one right-shift mux level by SHIFT with its pipeline register
// Sticky register and ports exist only when SHIFTER_STICKY_EN is defined.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1,
    parameter int SHW   = 5,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [TAG_W-1:0] tag_i,
`ifdef SHIFTER_STICKY_EN
    input  logic             sticky_i,
    output logic             sticky_o,
`endif
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       op_o,
    output logic [SHW-1:0]   shamt_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int BIT = $clog2(SHIFT);

    logic             valid_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       op_q;
    logic [SHW-1:0]   shamt_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] shifted;
    logic             take;

    assign take = load_i && valid_i;

    // SLL arrives bit-reversed, so every op is a right shift here.
    always_comb begin
        shifted = {{SHIFT{1'b0}}, data_i[WIDTH-1:SHIFT]};
        case (op_i)
            OP_SRA:  shifted = {{SHIFT{data_i[WIDTH-1]}}, data_i[WIDTH-1:SHIFT]};
            OP_ROR:  shifted = {data_i[SHIFT-1:0], data_i[WIDTH-1:SHIFT]};
            default: shifted = {{SHIFT{1'b0}}, data_i[WIDTH-1:SHIFT]};
        endcase
        data_d = shamt_i[BIT] ? shifted : data_i;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            shamt_q <= '0;
            tag_q   <= '0;
        end else begin
            if (load_i) begin
                valid_q <= valid_i;
            end
            if (take) begin
                data_q  <= data_d;
                op_q    <= op_i;
                shamt_q <= shamt_i;
                tag_q   <= tag_i;
            end
        end
    end

`ifdef SHIFTER_STICKY_EN
    logic sticky_q, sticky_d;

    assign sticky_d = sticky_i | (shamt_i[BIT] && (op_i != OP_ROR) && (|data_i[SHIFT-1:0]));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sticky_q <= 1'b0;
        end else if (take) begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_o = sticky_q;
`endif

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign op_o    = op_q;
    assign shamt_o = shamt_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - SHW-stage SLL/SRL/SRA/ROR shifter with valid/ready on both sides
// Optional sticky output enabled by SHIFTER_STICKY_EN.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sticky
);

    logic             valid_a [0:SHW];
    logic [WIDTH-1:0] data_a  [0:SHW];
    logic [1:0]       op_a    [0:SHW];
    logic [SHW-1:0]   shamt_a [0:SHW];
    logic [TAG_W-1:0] tag_a   [0:SHW];
    logic [SHW:0]     load;
    logic [SHW-1:0]   unused_shamt;

    assign valid_a[0] = in_valid;
    assign data_a[0]  = (in_op == OP_SLL) ? WIDTH'(bit_reverse(MAX_W'(in_data), WIDTH)) : in_data;
    assign op_a[0]    = in_op;
    assign shamt_a[0] = in_shamt;
    assign tag_a[0]   = in_tag;

    // A stage loads when empty or when its successor loads; resolved back from out_ready.
    always_comb begin
        load      = '0;
        load[SHW] = out_ready;
        for (int k = SHW - 1; k >= 0; k--) begin
            load[k] = !valid_a[k+1] || load[k+1];
        end
    end

    assign in_ready = load[0];

`ifdef SHIFTER_STICKY_EN
    logic sticky_a [0:SHW];
    assign sticky_a[0] = 1'b0;
`endif

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k),
            .SHW   (SHW),
            .TAG_W (TAG_W)
        ) u_stage (
            .clock    (clock),
            .reset_n  (reset_n),
            .load_i   (load[k]),
            .valid_i  (valid_a[k]),
            .data_i   (data_a[k]),
            .op_i     (op_a[k]),
            .shamt_i  (shamt_a[k]),
            .tag_i    (tag_a[k]),
`ifdef SHIFTER_STICKY_EN
            .sticky_i (sticky_a[k]),
            .sticky_o (sticky_a[k+1]),
`endif
            .valid_o  (valid_a[k+1]),
            .data_o   (data_a[k+1]),
            .op_o     (op_a[k+1]),
            .shamt_o  (shamt_a[k+1]),
            .tag_o    (tag_a[k+1])
        );
    end

    assign unused_shamt = shamt_a[SHW];

    assign out_valid = valid_a[SHW];
    assign out_data  = (op_a[SHW] == OP_SLL) ? WIDTH'(bit_reverse(MAX_W'(data_a[SHW]), WIDTH))
                                             : data_a[SHW];
    assign out_tag   = tag_a[SHW];

`ifdef SHIFTER_STICKY_EN
    assign out_sticky = sticky_a[SHW];
`else
    assign out_sticky = 1'b0;
`endif

endmodule
